// File: rtl/score_pkg.sv
// Shared constants, segment table and FSM state type for the score overlay.
package score_pkg;

    localparam logic [11:0] DIGIT_W = 12'd24;
    localparam logic [11:0] DIGIT_H = 12'd40;
    localparam logic [11:0] SEG_T   = 12'd4;
    localparam logic [11:0] HALF_H  = 12'd20;
    localparam logic [11:0] MID_LO  = 12'd18;
    localparam logic [11:0] MID_HI  = 12'd22;

    typedef enum logic [0:0] {
        PLAY      = 1'b0,
        GAME_OVER = 1'b1
    } state_e;

    // Bit 6 = segment a ... bit 0 = segment g.
    function automatic logic [6:0] seg_pattern(input logic [3:0] v);
        case (v)
            4'd0:    seg_pattern = 7'h7E;
            4'd1:    seg_pattern = 7'h30;
            4'd2:    seg_pattern = 7'h6D;
            4'd3:    seg_pattern = 7'h79;
            4'd4:    seg_pattern = 7'h33;
            4'd5:    seg_pattern = 7'h5B;
            4'd6:    seg_pattern = 7'h5F;
            4'd7:    seg_pattern = 7'h70;
            4'd8:    seg_pattern = 7'h7F;
            4'd9:    seg_pattern = 7'h7B;
            default: seg_pattern = 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/seg7_digit_hit.sv
// Combinational test: is a box-relative pixel inside a lit segment of the digit.
module seg7_digit_hit
    import score_pkg::*;
(
    input  logic [11:0] rel_x_i,
    input  logic [11:0] rel_y_i,
    input  logic [3:0]  value_i,
    output logic        lit_o
);

    logic [6:0] segs;
    logic       in_box, top, mid, bot, upper, left, right;

    always_comb begin
        segs   = seg_pattern(value_i);
        in_box = (rel_x_i < DIGIT_W) && (rel_y_i < DIGIT_H);
        top    = rel_y_i < SEG_T;
        mid    = (rel_y_i >= MID_LO) && (rel_y_i < MID_HI);
        bot    = rel_y_i >= (DIGIT_H - SEG_T);
        upper  = rel_y_i < HALF_H;
        left   = rel_x_i < SEG_T;
        right  = rel_x_i >= (DIGIT_W - SEG_T);
        lit_o  = in_box & |(segs & {top, upper & right, ~upper & right, bot,
                                    ~upper & left, upper & left, mid});
    end

endmodule

// File: rtl/draw_score_overlay.sv
// Score keeper and two-digit seven-segment overlay, 2-clock pixel pipeline.
// Optional winner blink in GAME_OVER when SCORE_FLASH_EN is defined.
module draw_score_overlay
    import score_pkg::*;
#(
    parameter int          MAX_SCORE = 7,
    parameter logic [11:0] P1_X      = 12'd472,
    parameter logic [11:0] P2_X      = 12'd528,
    parameter logic [11:0] DIGIT_Y   = 12'd16,
    parameter logic [11:0] P1_COLOR  = 12'hf_0_0,
    parameter logic [11:0] P2_COLOR  = 12'h0_0_b
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        goal_p1,
    input  logic        goal_p2,
    input  logic        game_clear,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [3:0]  score_p1,
    output logic [3:0]  score_p2,
    output logic        game_over
);

    localparam logic [3:0] MAX_S = 4'(MAX_SCORE);

    state_e     state_q, state_d;
    logic [3:0] score1_q, score1_d, score2_q, score2_d;
    logic [3:0] disp1_q, disp2_q;
    logic       goal1_q, goal1_dly_q, goal2_q, goal2_dly_q, vblnk_dly_q;
    logic       ev1, ev2;

    assign ev1 = goal1_q & ~goal1_dly_q;
    assign ev2 = goal2_q & ~goal2_dly_q;

    always_comb begin
        state_d  = state_q;
        score1_d = score1_q;
        score2_d = score2_q;
        case (state_q)
            PLAY: begin
                if (game_clear) begin
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                end else if (ev1 && !ev2) begin
                    score1_d = score1_q + 4'd1;
                    if (score1_d == MAX_S) state_d = GAME_OVER;
                end else if (ev2 && !ev1) begin
                    score2_d = score2_q + 4'd1;
                    if (score2_d == MAX_S) state_d = GAME_OVER;
                end
            end
            GAME_OVER: begin
                if (game_clear) begin
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                    state_d  = PLAY;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= PLAY;
            score1_q    <= 4'd0;
            score2_q    <= 4'd0;
            goal1_q     <= 1'b0;
            goal1_dly_q <= 1'b0;
            goal2_q     <= 1'b0;
            goal2_dly_q <= 1'b0;
            vblnk_dly_q <= 1'b0;
            disp1_q     <= 4'd0;
            disp2_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            goal1_q     <= goal_p1;
            goal1_dly_q <= goal1_q;
            goal2_q     <= goal_p2;
            goal2_dly_q <= goal2_q;
            vblnk_dly_q <= vblnk_in;
            // Frame-boundary snapshot keeps a frame from showing a half-updated score.
            if (vblnk_in && !vblnk_dly_q) begin
                disp1_q <= score1_q;
                disp2_q <= score2_q;
            end
        end
    end

    assign score_p1  = score1_q;
    assign score_p2  = score2_q;
    assign game_over = (state_q == GAME_OVER);

    logic show1, show2;
`ifdef SCORE_FLASH_EN
    logic       vsync_dly_q;
    logic [7:0] frame_q;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            vsync_dly_q <= 1'b0;
            frame_q     <= 8'd0;
        end else begin
            vsync_dly_q <= vsync_in;
            if (vsync_in && !vsync_dly_q) frame_q <= frame_q + 8'd1;
        end
    end

    assign show1 = !(game_over && score1_q == MAX_S) || frame_q[4];
    assign show2 = !(game_over && score2_q == MAX_S) || frame_q[4];
`else
    assign show1 = 1'b1;
    assign show2 = 1'b1;
`endif

    logic [11:0] rel1_x, rel2_x, rel_y;
    logic        in1, in2, lit1, lit2;

    always_comb begin
        rel1_x = hcount_in - P1_X;
        rel2_x = hcount_in - P2_X;
        rel_y  = vcount_in - DIGIT_Y;
        in1    = (hcount_in >= P1_X) && (vcount_in >= DIGIT_Y);
        in2    = (hcount_in >= P2_X) && (vcount_in >= DIGIT_Y);
    end

    seg7_digit_hit u_hit_p1 (.rel_x_i(rel1_x), .rel_y_i(rel_y), .value_i(disp1_q), .lit_o(lit1));
    seg7_digit_hit u_hit_p2 (.rel_x_i(rel2_x), .rel_y_i(rel_y), .value_i(disp2_q), .lit_o(lit2));

    logic [11:0] h1_q, v1_q, rgb1_q;
    logic        hs1_q, vs1_q, hb1_q, vb1_q, hit1_q, hit2_q;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            h1_q <= '0; v1_q <= '0; rgb1_q <= '0;
            hs1_q <= 1'b0; vs1_q <= 1'b0; hb1_q <= 1'b0; vb1_q <= 1'b0;
            hit1_q <= 1'b0; hit2_q <= 1'b0;
            hcount_out <= '0; vcount_out <= '0; rgb_out <= '0;
            hsync_out <= 1'b0; vsync_out <= 1'b0; hblnk_out <= 1'b0; vblnk_out <= 1'b0;
        end else begin
            h1_q   <= hcount_in;
            v1_q   <= vcount_in;
            rgb1_q <= rgb_in;
            hs1_q  <= hsync_in;
            vs1_q  <= vsync_in;
            hb1_q  <= hblnk_in;
            vb1_q  <= vblnk_in;
            hit1_q <= in1 & lit1 & show1;
            hit2_q <= in2 & lit2 & show2;

            hcount_out <= h1_q;
            vcount_out <= v1_q;
            hsync_out  <= hs1_q;
            vsync_out  <= vs1_q;
            hblnk_out  <= hb1_q;
            vblnk_out  <= vb1_q;
            if (hb1_q || vb1_q) rgb_out <= 12'h0_0_0;
            else if (hit1_q)    rgb_out <= P1_COLOR;
            else if (hit2_q)    rgb_out <= P2_COLOR;
            else                rgb_out <= rgb1_q;
        end
    end

endmodule
